// File: rtl/pc_pkg.sv
// Shared definitions for the PC / return-stack stage: next-PC select codes,
// default widths and a width-generic sign-extension helper.
package pc_pkg;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_OFFSET_W = 8;

    // Replicates bit (width-1) of value into every higher bit of a 32-bit result.
    function automatic logic [31:0] sign_extend(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] res;
        logic [4:0]  msb;
        msb = 5'(width - 1);
        for (int i = 0; i < 32; i++) begin
            res[i] = (i < int'(width)) ? value[i] : value[msb];
        end
        return res;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO with occupancy count and full/empty/overflow/underflow status.
// With PC_STACK_WRAP_EN defined the storage is circular and a full push overwrites the oldest entry.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_wdata,
    output logic [ADDR_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;

    logic [PTR_W-1:0]  w_top_m1;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_top_m1 = r_top - PTR_W'(1);

`ifdef PC_STACK_WRAP_EN
    assign w_do_push  = i_push;
    assign o_overflow = 1'b0;
`else
    assign w_do_push  = i_push & ~w_full;
    assign o_overflow = i_push & w_full;
`endif

    assign w_do_pop    = i_pop & ~w_empty;
    assign o_underflow = i_pop & w_empty;

    assign o_rdata = r_mem[w_top_m1];
    assign o_full  = w_full;
    assign o_empty = w_empty;

    // r_top indexes the next free slot; power-of-two depth lets it wrap for free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            r_top <= r_top + PTR_W'(1);
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_top   <= w_top_m1;
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_top] <= i_wdata;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC mux (sequential/branch/jump/return) and a JSR/RET return stack.
// Define PC_STACK_WRAP_EN for a circular return stack that overwrites its oldest entry when full.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DEPTH    = 8,
    parameter int unsigned       OFFSET_W = DEF_OFFSET_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enablePC,
    input  logic [1:0]          selectAdress,
    input  logic                push,
    input  logic                pop,
    input  logic                RET,
    input  logic [ADDR_W-1:0]   jumpAdress,
    input  logic [OFFSET_W-1:0] branchOffset,
    output logic [ADDR_W-1:0]   pc,
    output logic                stackFull,
    output logic                stackEmpty,
    output logic                stackError
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_error;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_offset_ext;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_stk_rdata;
    logic              w_ret;
    logic              w_conflict;
    logic              w_stk_push;
    logic              w_stk_pop;
    logic              w_stk_full;
    logic              w_stk_empty;
    logic              w_overflow;
    logic              w_underflow;
    logic              w_err_set;

    assign w_seq        = r_pc + ADDR_W'(1);
    assign w_offset_ext = ADDR_W'(sign_extend(32'(branchOffset), OFFSET_W));
    assign w_ret        = pop & RET;
    assign w_conflict   = push & w_ret;

    // Stack strobes already carry the enable and the priority decision.
    assign w_stk_push = enablePC & push & ~w_ret & (selectAdress == SEL_JUMP);
    assign w_stk_pop  = enablePC & w_ret & ~push;

    return_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_return_stack (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_stk_push),
        .i_pop       (w_stk_pop),
        .i_wdata     (w_seq),
        .o_rdata     (w_stk_rdata),
        .o_full      (w_stk_full),
        .o_empty     (w_stk_empty),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    always_comb begin
        w_pc_next = w_seq;
        if (w_conflict) begin
            w_pc_next = w_seq;
        end else if (w_ret) begin
            w_pc_next = w_stk_empty ? w_seq : w_stk_rdata;
        end else begin
            case (selectAdress)
                SEL_JUMP:   w_pc_next = jumpAdress;
                SEL_BRANCH: w_pc_next = w_seq + w_offset_ext;
                default:    w_pc_next = w_seq;
            endcase
        end
    end

    assign w_err_set = enablePC & (w_conflict | w_underflow | w_overflow);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_error <= 1'b0;
        end else if (enablePC) begin
            r_pc <= w_pc_next;
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign pc         = r_pc;
    assign stackFull  = w_stk_full;
    assign stackEmpty = w_stk_empty;
    assign stackError = r_error;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based reference model.
// Honours PC_STACK_WRAP_EN the same way the design does.
module tb_pc_stack_unit;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enablePC = 1'b0;
    logic [1:0]  selectAdress = 2'b00;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        RET = 1'b0;
    logic [11:0] jumpAdress = '0;
    logic [7:0]  branchOffset = '0;
    logic [11:0] pc;
    logic        stackFull;
    logic        stackEmpty;
    logic        stackError;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] m_pc = '0;
    logic        m_err = 1'b0;
    logic [11:0] m_stack [$];

    pc_stack_unit dut (
        .clock        (clock),
        .reset        (reset),
        .enablePC     (enablePC),
        .selectAdress (selectAdress),
        .push         (push),
        .pop          (pop),
        .RET          (RET),
        .jumpAdress   (jumpAdress),
        .branchOffset (branchOffset),
        .pc           (pc),
        .stackFull    (stackFull),
        .stackEmpty   (stackEmpty),
        .stackError   (stackError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".empty"}, 32'(stackEmpty), 32'(m_stack.size() == 0));
        check({tag, ".full"}, 32'(stackFull), 32'(m_stack.size() == DEPTH));
        check({tag, ".err"}, 32'(stackError), 32'(m_err));
    endtask

    // Reference behaviour written straight from the next-PC rules.
    task automatic model_step(input logic en, input logic [1:0] sel, input logic psh,
                              input logic pp, input logic rt, input logic [11:0] jmp,
                              input logic [7:0] off);
        int seq;
        int soff;
        if (!en) return;
        seq  = (int'(m_pc) + 1) % 4096;
        soff = off[7] ? int'(off) - 256 : int'(off);
        if (psh && pp && rt) begin
            m_pc  = 12'(seq);
            m_err = 1'b1;
        end else if (pp && rt) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else begin
                m_pc  = 12'(seq);
                m_err = 1'b1;
            end
        end else if (sel == 2'b10) begin
            m_pc = jmp;
            if (psh) begin
                if (m_stack.size() < DEPTH) begin
                    m_stack.push_back(12'(seq));
                end else begin
`ifdef PC_STACK_WRAP_EN
                    void'(m_stack.pop_front());
                    m_stack.push_back(12'(seq));
`else
                    m_err = 1'b1;
`endif
                end
            end
        end else if (sel == 2'b01) begin
            m_pc = 12'((seq + soff + 8192) % 4096);
        end else begin
            m_pc = 12'(seq);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] sel, input logic psh, input logic pp,
                        input logic rt, input logic [11:0] jmp, input logic [7:0] off,
                        input string tag);
        enablePC     = en;
        selectAdress = sel;
        push         = psh;
        pop          = pp;
        RET          = rt;
        jumpAdress   = jmp;
        branchOffset = off;
        model_step(en, sel, psh, pp, rt, jmp, off);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        enablePC = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        RET      = 1'b0;
        reset    = 1'b1;
        #1;
        m_pc  = '0;
        m_err = 1'b0;
        m_stack.delete();
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #12;
        reset = 1'b0;
        m_stack.delete();
        check_all("reset");

        // Sequential counting
        for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 0, 0, 12'h000, 8'h00, "seq");

        // Branches, negative and wrapping
        step(1, 2'b10, 0, 0, 0, 12'h010, 8'h00, "jmp_010");
        step(1, 2'b01, 0, 0, 0, 12'h000, 8'hFC, "br_neg");
        check("br_neg_val", 32'(pc), 32'h00D);
        step(1, 2'b10, 0, 0, 0, 12'hFFE, 8'h00, "jmp_ffe");
        step(1, 2'b01, 0, 0, 0, 12'h000, 8'h05, "br_wrap");
        check("br_wrap_val", 32'(pc), 32'h004);

        // JSR then RET
        step(1, 2'b10, 0, 0, 0, 12'h020, 8'h00, "jmp_020");
        step(1, 2'b10, 1, 0, 0, 12'h100, 8'h00, "jsr_100");
        step(1, 2'b00, 0, 1, 1, 12'h000, 8'h00, "ret");
        check("ret_val", 32'(pc), 32'h021);

        // Pop alone / RET alone are ignored
        step(1, 2'b00, 0, 1, 0, 12'h000, 8'h00, "pop_only");
        step(1, 2'b00, 0, 0, 1, 12'h000, 8'h00, "ret_only");

        // Nine nested JSRs, then unwind eight
        for (int i = 0; i < 9; i++) step(1, 2'b10, 1, 0, 0, 12'(12'h200 + i * 16), 8'h00, "jsr_nest");
        for (int i = 0; i < 8; i++) step(1, 2'b00, 0, 1, 1, 12'h000, 8'h00, "ret_nest");
        do_reset("reset_after_nest");

        // RET on empty stack; error is sticky
        step(1, 2'b10, 0, 0, 0, 12'h050, 8'h00, "jmp_050");
        step(1, 2'b00, 0, 1, 1, 12'h000, 8'h00, "ret_empty");
        check("ret_empty_err", 32'(stackError), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 0, 0, 12'h000, 8'h10, "err_sticky");
        do_reset("reset_clears_err");

        // Disabled update holds everything
        step(1, 2'b00, 0, 0, 0, 12'h000, 8'h00, "pre_hold");
        step(0, 2'b10, 1, 0, 0, 12'h3AB, 8'h00, "hold");

        // Async reset mid-cycle after two pushes
        step(1, 2'b10, 1, 0, 0, 12'h400, 8'h00, "push_a");
        step(1, 2'b10, 1, 0, 0, 12'h500, 8'h00, "push_b");
        do_reset("async_reset");

        // push together with an effective return
        step(1, 2'b10, 1, 0, 0, 12'h600, 8'h00, "push_c");
        step(1, 2'b10, 1, 1, 1, 12'h700, 8'h00, "conflict");
        do_reset("reset_rand");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                 12'($urandom), 8'($urandom), "rand");
            if (i == 200) do_reset("reset_mid_rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and return-address-stack stage directly downstream of the instruction controller.
- Consumes selectAdress, push, pop, RET and enablePC, together with the jump/branch fields of the current 19-bit instruction.
- Produces the registered instruction-memory address `pc`.
- Owns a hardware LIFO of return addresses for JSR/RET, with full/empty status and a sticky error flag.

Parameters:
- ADDR_W, 12, width of instruction address and PC.
- DEPTH, 8, number of return-stack entries (power of two, at least 2).
- OFFSET_W, 8, width of the signed branch offset field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enablePC  input  1  PC update enable; when low, pc and the stack hold.
- selectAdress  input  2  next-PC select: 00 sequential, 01 branch taken, 10 jump/JSR, 11 reserved.
- push  input  1  JSR: store the return address on the stack.
- pop  input  1  RET: pop the stack.
- RET  input  1  RET qualifier; pop takes effect only when pop and RET are both 1.
- jumpAdress  input  ADDR_W  absolute target, instruction bits [11:0].
- branchOffset  input  OFFSET_W  signed branch displacement, instruction bits [7:0].
- pc  output  ADDR_W  current instruction address (registered).
- stackFull  output  1  high when count==DEPTH.
- stackEmpty  output  1  high when count==0.
- stackError  output  1  sticky overflow/underflow/conflict flag.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, stack pointer/count=0, stackEmpty=1, stackFull=0, stackError=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts any pending update immediately.
- Updates happen only on a rising clock edge with enablePC=1; otherwise all state holds.
- Define seq = pc+1 mod 2^ADDR_W.
- Effective return = pop & RET. Pop alone, or RET alone, is ignored (treated as sequential unless selectAdress says otherwise).
- Next-PC priority, highest first:
  1. Conflict (push & effective return):
     - pc<=seq, no stack change, stackError<=1.
  2. Effective return:
     - If count>0: pc<=stack[top], count<=count-1.
     - If empty: pc<=seq, stackError<=1.
  3. selectAdress=10 (jump):
     - pc<=jumpAdress.
     - If push=1 and count<DEPTH: stack[count]<=seq, count<=count+1.
     - If push=1 and full: the jump is still taken, the push is dropped, stackError<=1.
  4. selectAdress=01 (branch):
     - pc<=seq + sign_extend(branchOffset), computed mod 2^ADDR_W.
  5. selectAdress=00 or 11: pc<=seq.
- push with selectAdress≠10 is ignored; no stack change.
- Arithmetic:
  - The offset is sign-extended to ADDR_W before the add.
  - Overflow wraps silently: 0xFFF+1=0x000.
  - Negative offsets wrap below 0.
- Latency:
  - The new pc is visible one cycle after the decision edge.
  - A return address pushed at edge N can be popped at edge N+1.
- stackFull and stackEmpty are decoded from the registered count, so there is no combinational path from the inputs.
- stackError clears only on reset.

Optional Feature:
- Macro: PC_STACK_WRAP_EN.
- Defined:
  - The stack is a circular buffer.
  - A push when full overwrites the oldest entry; count stays DEPTH; stackError is not set.
  - Underflow and conflict still set stackError.
- Undefined: the overflow behaviour in Behaviour rule 3 applies (push dropped, stackError set).

Decomposition:
- Shared package pc_pkg:
  - Select encodings SEL_SEQ=2'b00, SEL_BRANCH=2'b01, SEL_JUMP=2'b10, SEL_RSVD=2'b11.
  - Default ADDR_W and OFFSET_W.
  - sign_extend helper function.
- Sub-module return_stack:
  - Parameterised by DEPTH and ADDR_W.
  - Contains the LIFO storage and count.
  - push/pop/wdata in; rdata/full/empty/overflow/underflow out.
- The PC mux and the PC register stay in pc_stack_unit.

Test Plan:
1. Reset, then 3 cycles with enablePC=1, selectAdress=00: pc 0→1→2→3; stackEmpty=1.
2. pc=0x010, selectAdress=01, branchOffset=0xFC (-4): pc=0x00D. Then branchOffset=0x05 at pc=0xFFE: pc=0x004 (wrap).
3. JSR at pc=0x020 to 0x100 (selectAdress=10, push=1); then RET (pop=RET=1): pc 0x100, then 0x021; count 1→0.
4. Nine nested JSRs with DEPTH=8:
   - Without macro: ninth push dropped, stackError=1, stackFull=1, eight RETs unwind correctly.
   - With PC_STACK_WRAP_EN: stackError=0, oldest entry lost.
5. RET on empty stack at pc=0x050: pc=0x051, stackError=1 and stays 1 until reset.
6. Edge cases:
   - enablePC=0 with selectAdress=10: pc holds.
   - Reset asserted mid-cycle after two pushes: pc=0, count=0 asynchronously.
   - push=1 with pop=RET=1: pc=seq, stackError=1.
